// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction-memory and ID-packet handshake bundle
interface if_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst0;
    logic [31:0] if_inst1;
    logic        if_adel;

    modport master (
        output inst_req, inst_addr, if_valid, if_pc, if_inst0, if_inst1, if_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, id_ready
    );

    modport slave (
        input  inst_req, inst_addr, if_valid, if_pc, if_inst0, if_inst1, if_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, id_ready
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch PC sequencer with redirect arbitration and skid-buffered ID packet
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter logic [31:0] PC_STEP  = 32'd8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic [31:0]     exc_pc,
    input  logic            br_valid,
    input  logic [31:0]     br_target,
    input  logic            br_ds_fetched,
    if_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_ERR} state_t;

    state_t      state, state_n;
    logic [31:0] pc_r, pc_n;
    logic        discard, discard_n;
    logic        br_pend, br_pend_n;
    logic [31:0] br_pend_target, br_pend_target_n;
    logic        out_valid, out_valid_n;
    logic [31:0] out_pc, out_pc_n;
    logic [31:0] out_inst0, out_inst0_n;
    logic [31:0] out_inst1, out_inst1_n;
    logic        out_adel, out_adel_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] skid_inst0, skid_inst0_n;
    logic [31:0] skid_inst1, skid_inst1_n;

    logic        req;
    logic        flush;
    logic [31:0] flush_pc;
    logic        new_br;
    logic        slot_free;

    // A misaligned PC never reaches memory; it is reported as an address-error packet instead.
    assign req       = !reset && (state == S_REQ) && (pc_r[1:0] == 2'b00);
    assign flush     = exc_valid || (br_valid && br_ds_fetched);
    assign flush_pc  = exc_valid ? exc_pc : br_target;
    assign new_br    = br_valid && !br_ds_fetched && !exc_valid;
    assign slot_free = !out_valid || bus.id_ready;

    assign bus.inst_req  = req;
    assign bus.inst_addr = pc_r;
    assign bus.if_valid  = out_valid;
    assign bus.if_pc     = out_pc;
    assign bus.if_inst0  = out_inst0;
    assign bus.if_inst1  = out_inst1;
    assign bus.if_adel   = out_adel;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_REQ;
            pc_r           <= RESET_PC;
            discard        <= 1'b0;
            br_pend        <= 1'b0;
            br_pend_target <= '0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_inst0      <= '0;
            out_inst1      <= '0;
            out_adel       <= 1'b0;
            skid_pc        <= '0;
            skid_inst0     <= '0;
            skid_inst1     <= '0;
        end else begin
            state          <= state_n;
            pc_r           <= pc_n;
            discard        <= discard_n;
            br_pend        <= br_pend_n;
            br_pend_target <= br_pend_target_n;
            out_valid      <= out_valid_n;
            out_pc         <= out_pc_n;
            out_inst0      <= out_inst0_n;
            out_inst1      <= out_inst1_n;
            out_adel       <= out_adel_n;
            skid_pc        <= skid_pc_n;
            skid_inst0     <= skid_inst0_n;
            skid_inst1     <= skid_inst1_n;
        end
    end

    // Next-state: redirects first, then the fetch FSM and the output/skid handshake.
    always_comb begin
        state_n          = state;
        pc_n             = pc_r;
        discard_n        = discard;
        br_pend_n        = br_pend;
        br_pend_target_n = br_pend_target;
        out_valid_n      = out_valid;
        out_pc_n         = out_pc;
        out_inst0_n      = out_inst0;
        out_inst1_n      = out_inst1;
        out_adel_n       = out_adel;
        skid_pc_n        = skid_pc;
        skid_inst0_n     = skid_inst0;
        skid_inst1_n     = skid_inst1;

        if (flush) begin
            pc_n        = flush_pc;
            out_valid_n = 1'b0;
            br_pend_n   = 1'b0;
            // A response still owed by memory must be swallowed before refetching.
            // If it lands in this very cycle it is already consumed, so nothing is owed.
            if ((state == S_WAIT && !bus.inst_data_ok) || (req && bus.inst_addr_ok)) begin
                discard_n = 1'b1;
                state_n   = S_WAIT;
            end else begin
                discard_n = 1'b0;
                state_n   = S_REQ;
            end
        end else begin
            if (out_valid && bus.id_ready) begin
                out_valid_n = 1'b0;
            end
            if (new_br) begin
                br_pend_n        = 1'b1;
                br_pend_target_n = br_target;
            end
            unique case (state)
                S_REQ: begin
                    if (!req) begin
                        if (slot_free) begin
                            out_valid_n = 1'b1;
                            out_pc_n    = pc_r;
                            out_inst0_n = '0;
                            out_inst1_n = '0;
                            out_adel_n  = 1'b1;
                            state_n     = S_ERR;
                        end
                    end else if (bus.inst_addr_ok) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_data_ok) begin
                        if (discard) begin
                            discard_n = 1'b0;
                            state_n   = S_REQ;
                        end else begin
                            if (slot_free) begin
                                out_valid_n = 1'b1;
                                out_pc_n    = pc_r;
                                out_inst0_n = bus.inst_rdata[31:0];
                                out_inst1_n = bus.inst_rdata[63:32];
                                out_adel_n  = 1'b0;
                                state_n     = S_REQ;
                            end else begin
                                skid_pc_n    = pc_r;
                                skid_inst0_n = bus.inst_rdata[31:0];
                                skid_inst1_n = bus.inst_rdata[63:32];
                                state_n      = S_FULL;
                            end
                            // This packet is the delay slot of any branch seen so far.
                            if (new_br) begin
                                pc_n = br_target;
                            end else if (br_pend) begin
                                pc_n = br_pend_target;
                            end else begin
                                pc_n = pc_r + PC_STEP;
                            end
                            br_pend_n = 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.id_ready) begin
                        out_valid_n = 1'b1;
                        out_pc_n    = skid_pc;
                        out_inst0_n = skid_inst0;
                        out_inst1_n = skid_inst1;
                        out_adel_n  = 1'b0;
                        state_n     = S_REQ;
                    end
                end
                S_ERR: begin
                    state_n = S_ERR;
                end
                default: begin
                    state_n = S_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - randomized bench for if_fetch_ctrl against a packet-queue model
module tb_if_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        br_ds_fetched;

    if_fetch_ctrl_if bus();

    if_fetch_ctrl dut (
        .clk(clk),
        .reset(reset),
        .exc_valid(exc_valid),
        .exc_pc(exc_pc),
        .br_valid(br_valid),
        .br_target(br_target),
        .br_ds_fetched(br_ds_fetched),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        adel;
    } pkt_t;

    pkt_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_out;
    bit          m_stale;
    bit          m_err;
    bit          m_pend;

    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;
    bit          spur_en;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] req_log[$];
    logic [31:0] del_log[$];

    function automatic logic [31:0] word0(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] word1(input logic [31:0] a);
        return (a + 32'd4) ^ 32'h2468_ace0;
    endfunction

    function automatic bit m_req();
        return !reset && !m_out && !m_err && (mq.size() < 2) && (m_pc[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hdead_beef;
    endfunction

    function automatic logic [31:0] del_at(input int i);
        return (i < del_log.size()) ? del_log[i] : 32'hdead_beef;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom & 32'hffff_fff8;
        if ($urandom_range(0, 7) == 0) r = r | 32'd2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = RST_PC;
        m_tgt    = '0;
        m_out    = 0;
        m_stale  = 0;
        m_err    = 0;
        m_pend   = 0;
        mem_busy = 0;
        mem_cnt  = 0;
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_step();
        bit          req0;
        bit          dok;
        bit          nbr;
        logic [31:0] pc0;
        pkt_t        p;
        req0 = m_req();
        pc0  = m_pc;
        dok  = bus.inst_data_ok;
        if (reset) begin
            model_reset();
            return;
        end
        nbr = br_valid && !br_ds_fetched && !exc_valid;
        if (exc_valid || (br_valid && br_ds_fetched)) begin
            mq.delete();
            m_pend  = 0;
            m_err   = 0;
            m_out   = (m_out && !dok) || (req0 && bus.inst_addr_ok);
            m_stale = m_out;
            m_pc    = exc_valid ? exc_pc : br_target;
        end else begin
            if (mq.size() > 0 && bus.id_ready) void'(mq.pop_front());
            if (m_out && dok && !m_stale) begin
                p.pc = m_pc; p.i0 = word0(m_pc); p.i1 = word1(m_pc); p.adel = 0;
                mq.push_back(p);
                m_pc   = nbr ? br_target : (m_pend ? m_tgt : m_pc + 32'd8);
                m_pend = 0;
            end else if (nbr) begin
                m_pend = 1;
                m_tgt  = br_target;
            end
            if (m_out && dok) begin
                m_out   = 0;
                m_stale = 0;
            end else if (req0 && bus.inst_addr_ok) begin
                m_out = 1;
            end else if (!m_out && !m_err && m_pc[1:0] != 2'b00 && mq.size() == 0) begin
                p.pc = m_pc; p.i0 = '0; p.i1 = '0; p.adel = 1;
                mq.push_back(p);
                m_err = 1;
            end
        end
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (req0 && bus.inst_addr_ok) begin
            mem_busy = 1;
            mem_addr = pc0;
            mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
    endtask

    task automatic compare();
        bit r;
        r = m_req();
        chk("inst_req", 32'(bus.inst_req), 32'(r));
        if (r) chk("inst_addr", bus.inst_addr, m_pc);
        chk("if_valid", 32'(bus.if_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("if_pc", bus.if_pc, mq[0].pc);
            chk("if_inst0", bus.if_inst0, mq[0].i0);
            chk("if_inst1", bus.if_inst1, mq[0].i1);
            chk("if_adel", 32'(bus.if_adel), 32'(mq[0].adel));
        end
        if (bus.inst_req && bus.inst_addr_ok) req_log.push_back(bus.inst_addr);
        if (bus.if_valid && bus.id_ready && !reset) del_log.push_back(bus.if_pc);
    endtask

    task automatic tick();
        bus.inst_data_ok = (mem_busy && mem_cnt == 0) ||
                           (!mem_busy && spur_en && $urandom_range(0, 7) == 0);
        bus.inst_rdata   = mem_busy ? {word1(mem_addr), word0(mem_addr)} : {$urandom, $urandom};
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic restart(input int lat);
        reset            = 1;
        exc_valid        = 0;
        br_valid         = 0;
        br_ds_fetched    = 0;
        bus.inst_addr_ok = 1;
        bus.id_ready     = 1;
        spur_en          = 0;
        mem_lat          = lat;
        tick();
        chk("no_req_in_reset", 32'(bus.inst_req), 32'd0);
        tick();
        reset = 0;
        req_log.delete();
        del_log.delete();
    endtask

    initial begin
        reset = 1; exc_valid = 0; exc_pc = '0; br_valid = 0; br_target = '0; br_ds_fetched = 0;
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = '0; bus.id_ready = 1;
        spur_en = 0; mem_lat = 0;
        model_reset();

        // Sequential fetch, single-cycle memory.
        restart(0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst0", bus.if_inst0, 32'd0);
        chk("rst_if_adel", 32'(bus.if_adel), 32'd0);
        chk("rst_inst_addr", bus.inst_addr, RST_PC);
        repeat (8) tick();
        chk("t1_req0", req_at(0), 32'hbfc0_0000);
        chk("t1_req1", req_at(1), 32'hbfc0_0008);
        chk("t1_req2", req_at(2), 32'hbfc0_0010);
        chk("t1_del0", del_at(0), 32'hbfc0_0000);
        chk("t1_del1", del_at(1), 32'hbfc0_0008);

        // ID stalls: second packet parks in the skid buffer.
        restart(0);
        bus.id_ready = 0;
        repeat (5) tick();
        chk("t2_full_no_req", 32'(bus.inst_req), 32'd0);
        chk("t2_held_valid", 32'(bus.if_valid), 32'd1);
        chk("t2_held_pc", bus.if_pc, 32'hbfc0_0000);
        bus.id_ready = 1;
        repeat (8) tick();
        chk("t2_del0", del_at(0), 32'hbfc0_0000);
        chk("t2_del1", del_at(1), 32'hbfc0_0008);
        chk("t2_del2", del_at(2), 32'hbfc0_0010);

        // Exception while a response is outstanding.
        restart(2);
        tick();
        exc_valid = 1; exc_pc = 32'hbfc0_0380;
        tick();
        exc_valid = 0;
        chk("t3_flush_valid", 32'(bus.if_valid), 32'd0);
        req_log.delete(); del_log.delete();
        repeat (10) tick();
        chk("t3_req0", req_at(0), 32'hbfc0_0380);
        chk("t3_del0", del_at(0), 32'hbfc0_0380);

        // Branch with delay slot still to fetch.
        restart(0);
        tick(); tick();
        br_valid = 1; br_target = 32'hbfc0_0100; br_ds_fetched = 0;
        tick();
        br_valid = 0;
        repeat (8) tick();
        chk("t4_req1", req_at(1), 32'hbfc0_0008);
        chk("t4_req2", req_at(2), 32'hbfc0_0100);
        chk("t4_del1", del_at(1), 32'hbfc0_0008);
        chk("t4_del2", del_at(2), 32'hbfc0_0100);

        // Exception wins over a simultaneous branch.
        restart(1);
        tick();
        br_valid = 1; br_target = 32'hbfc0_0100; br_ds_fetched = 1;
        exc_valid = 1; exc_pc = 32'hbfc0_0380;
        tick();
        br_valid = 0; br_ds_fetched = 0; exc_valid = 0;
        repeat (10) tick();
        chk("t5_req1", req_at(1), 32'hbfc0_0380);
        chk("t5_req2", req_at(2), 32'hbfc0_0388);
        chk("t5_del0", del_at(0), 32'hbfc0_0380);

        // Misaligned branch target produces an address-error packet and parks.
        restart(1);
        bus.id_ready = 0;
        tick();
        br_valid = 1; br_target = 32'hbfc0_0102; br_ds_fetched = 1;
        tick();
        br_valid = 0; br_ds_fetched = 0;
        repeat (5) tick();
        chk("t6_no_req", 32'(bus.inst_req), 32'd0);
        chk("t6_valid", 32'(bus.if_valid), 32'd1);
        chk("t6_adel", 32'(bus.if_adel), 32'd1);
        chk("t6_pc", bus.if_pc, 32'hbfc0_0102);
        chk("t6_inst0", bus.if_inst0, 32'd0);
        chk("t6_inst1", bus.if_inst1, 32'd0);
        exc_valid = 1; exc_pc = 32'hbfc0_0380;
        tick();
        exc_valid = 0; bus.id_ready = 1;
        req_log.delete();
        repeat (6) tick();
        chk("t6_req0", req_at(0), 32'hbfc0_0380);

        // PC wraps modulo 2^32.
        restart(0);
        bus.inst_addr_ok = 0;
        tick();
        exc_valid = 1; exc_pc = 32'hffff_fff8;
        tick();
        exc_valid = 0; bus.inst_addr_ok = 1;
        repeat (6) tick();
        chk("t7_req0", req_at(0), 32'hffff_fff8);
        chk("t7_req1", req_at(1), 32'h0000_0000);

        // Randomized traffic.
        restart(-1);
        spur_en = 1;
        repeat (4000) begin
            reset            = ($urandom_range(0, 499) == 0);
            exc_valid        = ($urandom_range(0, 39) == 0);
            exc_pc           = rand_pc();
            br_valid         = ($urandom_range(0, 14) == 0);
            br_ds_fetched    = 1'($urandom_range(0, 1));
            br_target        = rand_pc();
            bus.inst_addr_ok = ($urandom_range(0, 9) < 6);
            bus.id_ready     = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer for the dual-issue front end. It owns the fetch PC and arbitrates next-PC sources: reset vector, exception redirect, branch/jump redirect with delay-slot deferral, and sequential +8. It drives the instruction-memory request/response handshake and delivers a two-instruction packet to ID through a valid/ready register with a one-entry skid buffer. Redirects flush in-flight fetches.

Parameters:
RESET_PC, 32'hbfc0_0000, fetch address after reset.
PC_STEP, 8, bytes advanced per delivered packet (two instructions).

Ports:
clk  in  1  clock, all logic on posedge.
reset  in  1  synchronous, active-high.
exc_valid  in  1  exception/interrupt redirect request.
exc_pc  in  32  exception handler address.
br_valid  in  1  branch/jump resolved taken in ID (one-cycle pulse).
br_target  in  32  branch/jump target.
br_ds_fetched  in  1  with br_valid: delay slot already delivered to ID.
inst_req  out  1  memory request valid.
inst_addr  out  32  request address (= pc_r).
inst_addr_ok  in  1  request accepted this cycle.
inst_data_ok  in  1  read data valid this cycle.
inst_rdata  in  64  {inst at pc+4, inst at pc}.
if_valid  out  1  packet valid to ID.
id_ready  in  1  ID accepts packet when if_valid && id_ready.
if_pc  out  32  packet PC.
if_inst0  out  32  instruction at if_pc.
if_inst1  out  32  instruction at if_pc+4.
if_adel  out  1  packet marks fetch address error; instructions are 0.

Behaviour:
- Reset (synchronous, high): pc_r=RESET_PC, state=S_REQ, if_valid=0, if_pc=0, if_inst0/1=0, if_adel=0, skid empty, discard=0, br_pend=0, inst_req=0 during the reset cycle.
- States: S_REQ, S_WAIT, S_FULL, S_ERR.
- S_REQ: if pc_r[1:0]!=0, no request; load output (if_valid=1, if_pc=pc_r, if_adel=1, insts=0) once the output slot is free, then go to S_ERR. Otherwise inst_req=1, inst_addr=pc_r; on inst_addr_ok go to S_WAIT. Request fields may change before inst_addr_ok.
- S_WAIT: inst_req=0. On inst_data_ok:
  - if discard=1: clear discard, go to S_REQ (pc_r already holds the redirect target).
  - else if the output slot is free (!if_valid || id_ready): load output with {pc_r, rdata}, go to S_REQ.
  - else: write the packet to skid, go to S_FULL.
  - In the non-discard cases, next pc_r = br_pend ? br_pend_target : pc_r+PC_STEP, and br_pend is cleared.
- S_FULL: no request. When id_ready, move skid to output and go to S_REQ.
- S_ERR: no request. Hold until exc_valid.
- ID handshake: output holds stable while if_valid && !id_ready. if_valid drops after acceptance if no new packet loads that cycle.
- Redirect priority: reset > exc_valid > br_valid > sequential.
- exc_valid: pc_r=exc_pc; clear if_valid, skid, br_pend. If state is S_WAIT, or S_REQ with inst_addr_ok this cycle, set discard=1 and stay in or enter S_WAIT; otherwise go to S_REQ.
- br_valid with br_ds_fetched=1: same flush action as exc_valid, using br_target.
- br_valid with br_ds_fetched=0: latch br_pend=1, br_pend_target=br_target. No flush; the next delivered packet carries the delay slot and the redirect is applied after it.
- br_valid in the same cycle as exc_valid is ignored.
- Only one outstanding memory request at a time. A data_ok outside S_WAIT is ignored.
- Address arithmetic is modulo 2^32 (0xFFFF_FFF8+8 wraps to 0).

Test Plan:
1. Reset, memory returns addr_ok and data_ok after 1 cycle, id_ready=1 -> inst_addr sequence 0xbfc00000, 0xbfc00008, 0xbfc00010; if_pc follows one packet behind; no request during reset.
2. id_ready=0 for 4 cycles after the first packet -> second packet goes to skid, state S_FULL, inst_req=0; when id_ready rises, packets 0xbfc00000 then 0xbfc00008 are delivered in order with no loss or duplication.
3. exc_valid with exc_pc=0xbfc00380 while in S_WAIT -> if_valid=0 next cycle; the pending data_ok is dropped; next inst_addr=0xbfc00380.
4. br_valid with br_target=0xbfc00100 and br_ds_fetched=0 while fetching 0xbfc00008 -> packet 0xbfc00008 is delivered, then inst_addr=0xbfc00100.
5. Same cycle: br_valid (target 0xbfc00100, br_ds_fetched=1) and exc_valid (0xbfc00380) -> next inst_addr=0xbfc00380; br_pend=0.
6. br_target=0xbfc00102 with br_ds_fetched=1 -> no inst_req; if_valid=1, if_adel=1, if_pc=0xbfc00102, insts=0; stays in S_ERR until exc_valid, then fetches exc_pc.
